// File: rtl/adc_sin_meas_pkg.sv
// Shared types and threshold helpers for the ADC sine measurement block.
// Pure definitions: no latency, no flow control.
package adc_sin_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN_HIGH,
    RUN_LOW
  } state_t;

  function automatic int unsigned mid_of(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

  function automatic int unsigned lo_th(input int unsigned data_w, input int unsigned hyst);
    return mid_of(data_w) - hyst;
  endfunction

  function automatic int unsigned hi_th(input int unsigned data_w, input int unsigned hyst);
    return mid_of(data_w) + hyst;
  endfunction

endpackage

// File: rtl/adc_sin_meas_peak.sv
// Running max/min tracker; restart loads both with the current sample.
// One-cycle registered update, no backpressure (caller qualifies with update/restart).
module sin_peak_track #(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              restart,
  input  logic              update,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      min_val <= '1;
    end else if (clear) begin
      max_val <= '0;
      min_val <= '1;
    end else if (restart) begin
      max_val <= sample;
      min_val <= sample;
    end else if (update) begin
      if (sample > max_val) max_val <= sample;
      if (sample < min_val) min_val <= sample;
    end
  end

endmodule

// File: rtl/adc_sin_meas.sv
// Rising mid-scale crossing detector with hysteresis; reports period and peak-to-peak per cycle.
// Result one cycle after the crossing sample; no backpressure, samples qualified by adc_valid.
module adc_sin_meas
  import adc_sin_meas_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int HYST   = 64,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              adc_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              clear,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] vpp,
  output logic              meas_valid,
  output logic              no_signal
);

  localparam logic [DATA_W-1:0] LO_TH   = DATA_W'(lo_th(DATA_W, HYST));
  localparam logic [DATA_W-1:0] HI_TH   = DATA_W'(hi_th(DATA_W, HYST));
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              is_low;
  logic              is_high;
  logic              crossing;
  logic              tracking;
  logic              cnt_hit;
  logic              timeout;
  logic [DATA_W-1:0] pk_max;
  logic [DATA_W-1:0] pk_min;

  assign adc_clk  = clk;
  assign is_low   = adc_data < LO_TH;
  assign is_high  = adc_data > HI_TH;
  assign crossing = adc_valid && is_high && (state == ARMED || state == RUN_LOW);
  assign tracking = (state == RUN_HIGH) || (state == RUN_LOW);
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign cnt_hit  = (cnt_inc == CNT_MAX);
  assign timeout  = adc_valid && !crossing && (state != IDLE) && cnt_hit;

  sin_peak_track #(.DATA_W(DATA_W)) u_peak (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear || timeout),
    .restart (!clear && crossing),
    .update  (!clear && adc_valid && tracking && !crossing),
    .sample  (adc_data),
    .max_val (pk_max),
    .min_val (pk_min)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= '0;
      vpp        <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        cnt       <= '0;
        no_signal <= 1'b0;
      end else if (adc_valid) begin
        case (state)
          IDLE: begin
            if (is_low) begin
              state <= ARMED;
              cnt   <= '0;
            end
          end
          default: begin
            // The crossing sample opens the new period, so old max/min are reported as-is
            if (crossing) begin
              if (state == RUN_LOW) begin
                period     <= cnt;
                vpp        <= pk_max - pk_min;
                meas_valid <= 1'b1;
              end
              state <= RUN_HIGH;
              cnt   <= CNT_W'(1);
            end else if (cnt_hit) begin
              no_signal <= 1'b1;
              state     <= IDLE;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
              if (state == RUN_HIGH && is_low) state <= RUN_LOW;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sin_meas.sv
// Self-checking bench for adc_sin_meas against a queue-based crossing model.
module tb_adc_sin_meas;

  localparam int DW  = 14;
  localparam int HY  = 64;
  localparam int CW  = 10;
  localparam int LIM = (1 << CW) - 1;
  localparam int MID = 8192;
  localparam int LO  = MID - HY;
  localparam int HI  = MID + HY;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          adc_clk;
  logic [DW-1:0] adc_data = 14'(MID);
  logic          adc_valid = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] period;
  logic [DW-1:0] vpp;
  logic          meas_valid;
  logic          no_signal;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit seen_low;
  bit crossed;
  int arm_cnt;
  int win[$];
  int m_period;
  int m_vpp;
  bit m_mv;
  bit m_nosig;

  adc_sin_meas #(.DATA_W(DW), .HYST(HY), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_clk    (adc_clk),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .clear      (clear),
    .period     (period),
    .vpp        (vpp),
    .meas_valid (meas_valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    seen_low = 0; crossed = 0; arm_cnt = 0; win.delete();
    m_period = 0; m_vpp = 0; m_mv = 0; m_nosig = 0;
  endtask

  task automatic model_timeout();
    m_nosig = 1; seen_low = 0; crossed = 0; arm_cnt = 0; win.delete();
  endtask

  task automatic model(input bit v, input int d, input bit c);
    int mx, mn;
    m_mv = 0;
    if (c) begin
      seen_low = 0; crossed = 0; arm_cnt = 0; win.delete(); m_nosig = 0;
      return;
    end
    if (!v) return;
    if (d > HI && seen_low) begin
      if (crossed) begin
        mx = 0; mn = (1 << DW) - 1;
        foreach (win[k]) begin
          if (win[k] > mx) mx = win[k];
          if (win[k] < mn) mn = win[k];
        end
        m_period = win.size(); m_vpp = mx - mn; m_mv = 1;
      end
      crossed = 1; seen_low = 0; win.delete(); win.push_back(d);
      return;
    end
    if (crossed) begin
      win.push_back(d);
      if (d < LO) seen_low = 1;
      if (win.size() == LIM) model_timeout();
    end else if (seen_low) begin
      arm_cnt++;
      if (arm_cnt == LIM) model_timeout();
    end else if (d < LO) begin
      seen_low = 1; arm_cnt = 0;
    end
  endtask

  task automatic step(input bit v, input int d, input bit c);
    adc_valid = v; adc_data = d[DW-1:0]; clear = c;
    @(posedge clk);
    if (!rst_n) model_reset(); else model(v, d, c);
    #1;
    chk("meas_valid", 32'(meas_valid), 32'(m_mv));
    chk("period", 32'(period), 32'(m_period));
    chk("vpp", 32'(vpp), 32'(m_vpp));
    chk("no_signal", 32'(no_signal), 32'(m_nosig));
  endtask

  function automatic int sine_at(input int i, input int per, input int amp, input int off);
    real x;
    int r;
    x = 8192.0 + amp * $sin(6.283185307179586 * i / per) + off + 0.5;
    r = $rtoi(x);
    if (r < 0) r = 0;
    if (r > (1 << DW) - 1) r = (1 << DW) - 1;
    return r;
  endfunction

  // gap: idle cycles after each valid sample; noise: square +-noise, 3 samples per step
  task automatic run_sine(input int n, input int per, input int amp, input int noise,
                          input int gap, input int start);
    int off;
    for (int k = 0; k < n; k++) begin
      off = (noise == 0) ? 0 : ((((start + k) / 3) % 2) != 0 ? -noise : noise);
      step(1'b1, sine_at(start + k, per, amp, off), 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, int'($urandom_range(0, (1 << DW) - 1)), 1'b0);
    end
  endtask

  initial begin
    int per, amp, noise;
    model_reset();
    step(1'b0, MID, 1'b0);
    step(1'b0, MID, 1'b0);
    chk("adc_clk_fwd", 32'(adc_clk), 32'(clk));
    rst_n = 1'b1;

    // Constant mid-scale: never arms, no results
    for (int k = 0; k < 1000; k++) step(1'b1, MID, 1'b0);

    // One low sample then in-band samples until the armed counter saturates
    step(1'b1, 100, 1'b0);
    for (int k = 0; k < LIM + 5; k++) step(1'b1, MID + int'($urandom_range(0, 2 * HY)) - HY, 1'b0);
    chk("nosig_set", 32'(no_signal), 32'd1);
    run_sine(250, 100, 4000, 0, 0, 0);
    chk("nosig_sticky", 32'(no_signal), 32'd1);
    step(1'b1, MID, 1'b1);
    chk("nosig_cleared", 32'(no_signal), 32'd0);

    // Ideal sine, 100 samples/period
    run_sine(650, 100, 4000, 0, 0, 0);
    chk("ideal_period", 32'(period), 32'd100);
    chk("ideal_vpp_lo", 32'(vpp >= 14'd7999), 32'd1);
    chk("ideal_vpp_hi", 32'(vpp <= 14'd8000), 32'd1);

    // Square noise below the hysteresis width
    step(1'b1, MID, 1'b1);
    run_sine(650, 100, 4000, 50, 0, 0);
    chk("noisy_period", 32'(period), 32'd100);

    // 50 samples/period, valid every other cycle
    step(1'b1, MID, 1'b1);
    run_sine(400, 50, 4000, 0, 1, 0);
    chk("half_rate_period", 32'(period), 32'd50);

    // clear with a valid high sample mid-period
    run_sine(40, 50, 4000, 0, 0, 400);
    step(1'b1, 12000, 1'b1);
    run_sine(300, 100, 3000, 0, 0, 10);

    // Asynchronous reset between clock edges mid-period
    run_sine(130, 100, 4000, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period), 32'd0);
    chk("arst_vpp", 32'(vpp), 32'd0);
    chk("arst_meas_valid", 32'(meas_valid), 32'd0);
    chk("arst_no_signal", 32'(no_signal), 32'd0);
    model_reset();
    run_sine(3, 100, 4000, 0, 0, 60);
    rst_n = 1'b1;
    run_sine(400, 100, 4000, 0, 0, 0);

    // Randomised sines with random validity and noise
    for (int r = 0; r < 6; r++) begin
      per   = int'($urandom_range(20, 150));
      amp   = int'($urandom_range(300, 8000));
      noise = int'($urandom_range(0, 60));
      for (int k = 0; k < 4 * per; k++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, int'($urandom_range(0, (1 << DW) - 1)), 1'b0);
        step(1'b1, sine_at(k, per, amp, (((k / 3) % 2) != 0) ? -noise : noise), 1'b0);
      end
    end

    // Fully random samples with occasional clear
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << DW) - 1)),
           ($urandom_range(0, 49) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
